serv_fpu_mul_seq: RTL and testbench
===================================

# serv_fpu_mul_seq

Iterative single-precision (IEEE-754 binary32) floating-point multiplier that sits directly downstream of the SERV core's extension port. It consumes `o_ext_rs1`/`o_ext_rs2`/`o_ext_funct3`/`o_mdu_valid` and returns `i_ext_rd`/`i_ext_ready`. It trades latency for area: the mantissa product is formed by shift-add, one multiplier bit per cycle, fitting SERV's bit-serial philosophy.

## Interface
- `CANON_NAN`, default 32'h7FC00000: result returned for every NaN-producing case.
- `clk`  in  1  sole clock; all state on rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_valid`  in  1  operation request (from `o_mdu_valid`); held high by the core until `o_ready`.
- `i_funct3`  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101–111 reserved.
- `i_rs1`  in  32  operand A, binary32.
- `i_rs2`  in  32  operand B, binary32.
- `o_ready`  out  1  one-cycle completion pulse (to `i_ext_ready`).
- `o_rd`  out  32  result (to `i_ext_rd`). Valid in the `o_ready` cycle; held until the next operation is accepted.

Reset is asynchronous and active-low (`i_rst_n`); one clock (`clk`).

## Operation
- States: IDLE, UNPACK, MUL, NORM, ROUND, DONE.
- IDLE → UNPACK when `i_valid`=1. Latch operands and funct3. Later changes on the inputs are ignored.
- UNPACK:
  - Sign = sA^sB.
  - Subnormal inputs flush to signed zero.
  - Special-case priority:
    1. Any NaN, reserved funct3, or Inf×0 → `CANON_NAN`.
    2. Inf×finite → signed Inf.
    3. Zero×finite → signed zero.
  - A special case goes to DONE. Otherwise go to MUL with 10-bit signed exp = eA+eB−127, mantissas {1,frac}, and the 48-bit accumulator cleared.
- MUL: 24 cycles. Each cycle, if the current multiplier LSB is 1 add the multiplicand (24b) to the accumulator upper half, then shift right 1. A 5-bit counter counts 0..23 and wraps to NORM.
- NORM: if product[47]=1, keep [47:24] as mantissa and exp+1; else use [46:23]. Guard = next bit; sticky = OR of the remaining bits.
- ROUND, increment decision:
  - RNE: G & (L|S).
  - RTZ: never.
  - RDN: sign & (G|S).
  - RUP: ~sign & (G|S).
  - RMM: G.
  - Mantissa carry-out → exp+1.
- ROUND result selection:
  - exp ≥ 255 → overflow. RNE/RMM → Inf; RTZ → 0x7F7FFFFF with sign; RDN → −Inf if negative, else +max finite; RUP → +Inf if positive, else −max finite.
  - exp ≤ 0 → signed zero (flush-to-zero output).
  - Otherwise pack normally.
- DONE: `o_ready`=1 for one cycle, `o_rd` updated; → IDLE.
- `i_valid` is not checked after acceptance. Dropping it mid-operation does not abort.
- If `i_valid` is still high in IDLE after DONE, a new operation is accepted. The core deasserts valid in the cycle after `o_ready`.
- No exception flags are produced.

## Timing
- Reset values: `o_ready`=0, `o_rd`=32'h0, state IDLE, counter 0, accumulator 0.
- Let acceptance be cycle N (IDLE with `i_valid`=1).
  - Normal path: UNPACK at N+1, MUL N+2..N+25, NORM N+26, ROUND N+27, `o_ready` high at N+28.
  - Special path: `o_ready` high at N+2.
- Throughput: one operation per 29 cycles (normal), since IDLE always separates operations.
- Reset asserted mid-operation: state, counter and outputs clear immediately. The pending result is lost and `o_ready` never pulses. The first operation after release behaves exactly as from power-up.
- `o_ready` is never asserted in two consecutive cycles.

## Configuration
- `SERV_FPU_MUL_RADIX4_EN` defined:
  - MUL retires 2 multiplier bits per cycle (adds 0/1/2/3× multiplicand), 12 cycles.
  - Normal `o_ready` at N+16. Counter counts 0..11.
  - Results are bit-identical to the radix-2 build.
- Not defined: radix-2 behaviour as specified above.

## Test plan
- 0x3FC00000 × 0x40000000, RNE: `o_ready` at N+28 (N+16 with radix-4), `o_rd`=0x40400000. `o_ready` is exactly one cycle wide.
- 0x3FFFFFFF × 0x3FFFFFFF: RNE and RTZ → 0x407FFFFE; RUP → 0x407FFFFF.
- 0x7F000000 × 0x7F000000: RNE → 0x7F800000; RTZ → 0x7F7FFFFF. 0xFF000000 × 0x7F000000, RUP → 0xFF7FFFFF.
- Special cases, each with `o_ready` at N+2:
  - 0x7F800000 × 0x00000000 → 0x7FC00000.
  - 0x80400000 × 0x3F800000 → 0x80000000 (subnormal flush).
  - funct3=111 with any operands → 0x7FC00000.
- Reset mid-operation: `i_rst_n` low at cycle N+12. Then `o_ready`=0 and `o_rd`=0 immediately, with no pulse afterwards. After release, 0x40000000 × 0x40000000 → 0x40800000 with normal latency.
- Back-to-back requests: `i_valid` reasserted the cycle after `o_ready`. The second operation is accepted in IDLE and completes 29 cycles after the first `o_ready`. `o_rd` holds the first result until then.

Source files
------------

// File: rtl/serv_fpu_mul_seq.sv
// Iterative binary32 multiplier behind the SERV extension port.
// Ports: clk, i_rst_n, i_valid, i_funct3 (rm), i_rs1, i_rs2 -> o_ready, o_rd.
// Build option: SERV_FPU_MUL_RADIX4_EN retires two multiplier bits per cycle.
module serv_fpu_mul_seq #(
  parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  output logic        o_ready,
  output logic [31:0] o_rd
);

  typedef enum logic [2:0] {
    IDLE, UNPACK, MUL, NORM, ROUND, DONE
  } state_t;

`ifdef SERV_FPU_MUL_RADIX4_EN
  localparam logic [4:0] CNT_LAST = 5'd11;
`else
  localparam logic [4:0] CNT_LAST = 5'd23;
`endif

  localparam logic [30:0] MAXF = 31'h7F7FFFFF;
  localparam logic [30:0] INF  = 31'h7F800000;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [31:0] a_q, b_q;
  logic [2:0]  rm_q;
  logic [9:0]  exp_q;
  logic [23:0] mcand_q, mplier_q;
  logic [47:0] acc_q;
  logic [23:0] mant_q;
  logic        grd_q, stk_q;

  // unpack
  logic        sgn;
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_zero, b_zero, a_inf, b_inf;
  logic        a_nan, b_nan, rsv;
  logic        is_nan, is_inf, is_zero, special;
  logic [31:0] spec_res;
  logic [9:0]  exp_init;

  assign sgn = a_q[31] ^ b_q[31];
  assign ea  = a_q[30:23];
  assign eb  = b_q[30:23];
  assign fa  = a_q[22:0];
  assign fb  = b_q[22:0];

  // exponent zero covers subnormals: they flush to zero
  assign a_zero = (ea == 8'h00);
  assign b_zero = (eb == 8'h00);
  assign a_inf  = (ea == 8'hFF) && (fa == '0);
  assign b_inf  = (eb == 8'hFF) && (fb == '0);
  assign a_nan  = (ea == 8'hFF) && (fa != '0);
  assign b_nan  = (eb == 8'hFF) && (fb != '0);
  assign rsv    = (rm_q > 3'd4);

  assign is_nan  = a_nan | b_nan | rsv |
                   (a_inf & b_zero) |
                   (a_zero & b_inf);
  assign is_inf  = a_inf | b_inf;
  assign is_zero = a_zero | b_zero;
  assign special = is_nan | is_inf | is_zero;

  always_comb begin
    spec_res = {sgn, 31'h0};
    if (is_nan)
      spec_res = CANON_NAN;
    else if (is_inf)
      spec_res = {sgn, INF};
  end

  assign exp_init = {2'b00, ea} + {2'b00, eb}
                  - 10'd127;

  // shift-add step
  logic [47:0] acc_nxt;
  logic [23:0] mplier_nxt;

`ifdef SERV_FPU_MUL_RADIX4_EN
  logic [25:0] pp;
  logic [25:0] sum4;

  always_comb begin
    pp = '0;
    unique case (mplier_q[1:0])
      2'd0: pp = '0;
      2'd1: pp = {2'b00, mcand_q};
      2'd2: pp = {1'b0, mcand_q, 1'b0};
      2'd3: pp = {2'b00, mcand_q}
               + {1'b0, mcand_q, 1'b0};
      default: pp = '0;
    endcase
  end

  assign sum4       = {2'b00, acc_q[47:24]} + pp;
  assign acc_nxt    = {sum4, acc_q[23:2]};
  assign mplier_nxt = {2'b00, mplier_q[23:2]};
`else
  logic [24:0] sum2;

  assign sum2 = {1'b0, acc_q[47:24]} +
                (mplier_q[0] ? {1'b0, mcand_q}
                             : 25'd0);
  assign acc_nxt    = {sum2, acc_q[23:1]};
  assign mplier_nxt = {1'b0, mplier_q[23:1]};
`endif

  // normalise
  logic        hi;
  logic [23:0] mant_n;
  logic        grd_n, stk_n;
  logic [9:0]  exp_n;

  assign hi     = acc_q[47];
  assign mant_n = hi ? acc_q[47:24] : acc_q[46:23];
  assign grd_n  = hi ? acc_q[23] : acc_q[22];
  assign stk_n  = hi ? (|acc_q[22:0])
                     : (|acc_q[21:0]);
  assign exp_n  = exp_q + {9'd0, hi};

  // round
  logic        rm_rne, rm_rtz, rm_rdn;
  logic        rm_rup, rm_rmm;
  logic        inc;
  logic [24:0] mant_r;
  logic [9:0]  exp_r;
  logic [22:0] frac_r;
  logic        ovf, ufl;
  logic [31:0] ovf_res, round_res;

  assign rm_rne = (rm_q == 3'd0);
  assign rm_rtz = (rm_q == 3'd1);
  assign rm_rdn = (rm_q == 3'd2);
  assign rm_rup = (rm_q == 3'd3);
  assign rm_rmm = (rm_q == 3'd4);

  always_comb begin
    inc = 1'b0;
    unique case (1'b1)
      rm_rne: inc = grd_q & (mant_q[0] | stk_q);
      rm_rtz: inc = 1'b0;
      rm_rdn: inc = sgn & (grd_q | stk_q);
      rm_rup: inc = ~sgn & (grd_q | stk_q);
      rm_rmm: inc = grd_q;
      default: inc = 1'b0;
    endcase
  end

  assign mant_r = {1'b0, mant_q} + {24'd0, inc};
  assign exp_r  = exp_q + {9'd0, mant_r[24]};
  assign frac_r = mant_r[24] ? mant_r[23:1]
                             : mant_r[22:0];
  assign ovf = ($signed(exp_r) >= 10'sd255);
  assign ufl = ($signed(exp_r) <= 10'sd0);

  always_comb begin
    ovf_res = {sgn, INF};
    unique case (1'b1)
      rm_rtz: ovf_res = {sgn, MAXF};
      rm_rdn: ovf_res = sgn ? {1'b1, INF}
                            : {1'b0, MAXF};
      rm_rup: ovf_res = sgn ? {1'b1, MAXF}
                            : {1'b0, INF};
      default: ovf_res = {sgn, INF};
    endcase
  end

  always_comb begin
    round_res = {sgn, exp_r[7:0], frac_r};
    if (ovf)
      round_res = ovf_res;
    else if (ufl)
      round_res = {sgn, 31'h0};
  end

  // control
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (i_valid) state_nxt = UNPACK;
      UNPACK: state_nxt = special ? DONE : MUL;
      MUL:    if (cnt == CNT_LAST)
                state_nxt = NORM;
      NORM:   state_nxt = ROUND;
      ROUND:  state_nxt = DONE;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // datapath
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rm_q     <= '0;
      exp_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      mant_q   <= '0;
      grd_q    <= 1'b0;
      stk_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (i_valid) begin
          a_q  <= i_rs1;
          b_q  <= i_rs2;
          rm_q <= i_funct3;
        end
        UNPACK: begin
          exp_q    <= exp_init;
          mcand_q  <= {1'b1, fa};
          mplier_q <= {1'b1, fb};
          acc_q    <= '0;
          cnt      <= '0;
        end
        MUL: begin
          acc_q    <= acc_nxt;
          mplier_q <= mplier_nxt;
          cnt      <= (cnt == CNT_LAST) ? 5'd0
                                        : cnt + 5'd1;
        end
        NORM: begin
          mant_q <= mant_n;
          grd_q  <= grd_n;
          stk_q  <= stk_n;
          exp_q  <= exp_n;
        end
        default: ;
      endcase
    end
  end

  // outputs
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ready <= 1'b0;
      o_rd    <= '0;
    end else begin
      o_ready <= (state_nxt == DONE);
      if (state == UNPACK && special)
        o_rd <= spec_res;
      else if (state == ROUND)
        o_rd <= round_res;
    end
  end

endmodule

// File: tb/tb_serv_fpu_mul_seq.sv
// Self-checking bench for serv_fpu_mul_seq.
// Directed, random, reset and back-to-back scenarios vs. a reference model.
module tb_serv_fpu_mul_seq;

`ifdef SERV_FPU_MUL_RADIX4_EN
  localparam int LAT = 16;
`else
  localparam int LAT = 28;
`endif

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic [2:0]  i_funct3;
  logic [31:0] i_rs1, i_rs2;
  logic        o_ready;
  logic [31:0] o_rd;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serv_fpu_mul_seq dut (
    .clk      (clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (i_valid),
    .i_funct3 (i_funct3),
    .i_rs1    (i_rs1),
    .i_rs2    (i_rs2),
    .o_ready  (o_ready),
    .o_rd     (o_rd)
  );

  // reference: exact integer product, rounded by remainder comparison
  function automatic logic [31:0] ref_mul(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [2:0]  rm,
    output bit         special
  );
    bit s;
    int ea, eb, e, sh;
    bit an, bn, ai, bi, az, bz, inc;
    longint ma, mb, p, q, rem, half;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    an = (ea == 255) && (a[22:0] != 0);
    bn = (eb == 255) && (b[22:0] != 0);
    ai = (ea == 255) && (a[22:0] == 0);
    bi = (eb == 255) && (b[22:0] == 0);
    az = (ea == 0);
    bz = (eb == 0);
    special = 1'b1;
    if (rm > 4 || an || bn || (ai && bz) || (az && bi))
      return 32'h7FC00000;
    if (ai || bi) return {s, 31'h7F800000};
    if (az || bz) return {s, 31'h0};
    special = 1'b0;
    ma = 64'h800000 + longint'(a[22:0]);
    mb = 64'h800000 + longint'(b[22:0]);
    p  = ma * mb;
    e  = ea + eb - 127;
    if (p >= (64'd1 << 47)) begin
      sh = 24;
      e  = e + 1;
    end else begin
      sh = 23;
    end
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    case (rm)
      3'd0: inc = (rem > half) || (rem == half && (q % 2) == 1);
      3'd2: inc = s && (rem != 0);
      3'd3: inc = !s && (rem != 0);
      3'd4: inc = (rem >= half);
      default: inc = 1'b0;
    endcase
    q = q + longint'(inc);
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) begin
      case (rm)
        3'd1: return {s, 31'h7F7FFFFF};
        3'd2: return s ? 32'hFF800000 : 32'h7F7FFFFF;
        3'd3: return s ? 32'hFF7FFFFF : 32'h7F800000;
        default: return {s, 31'h7F800000};
      endcase
    end
    if (e <= 0) return {s, 31'h0};
    return {s, 8'(e), 23'(q)};
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [7:0] e;
    int sel;
    sel = $urandom_range(0, 9);
    case (sel)
      0: e = 8'($urandom);
      1: e = 8'hFF;
      2: e = 8'h00;
      3: e = 8'($urandom_range(230, 254));
      4: e = 8'($urandom_range(1, 30));
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  // issue one request, report result and cycles from acceptance
  task automatic do_op(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  rm,
    output logic [31:0] res,
    output int          lat
  );
    i_rs1    = a;
    i_rs2    = b;
    i_funct3 = rm;
    i_valid  = 1'b1;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (o_ready === 1'b1) begin
        lat = k;
        break;
      end
    end
    res = o_rd;
    i_valid = 1'b0;
    if (lat < 0) begin
      tests++;
      fails++;
      $display("FAIL timeout a=%h b=%h rm=%0d", a, b, rm);
    end
    @(posedge clk);
    #1;
    tests++;
    if (o_ready !== 1'b0) begin
      fails++;
      $display("FAIL ready_width got %b want 0", o_ready);
    end
  endtask

  task automatic test_reset();
    i_rst_n  = 1'b0;
    i_valid  = 1'b0;
    i_funct3 = '0;
    i_rs1    = '0;
    i_rs2    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    i_rst_n = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (o_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_ready got %b want 0", o_ready);
    end
    tests++;
    if (o_rd !== 32'h0) begin
      fails++;
      $display("FAIL reset_rd got %h want 0", o_rd);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  rm;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic test_directed();
    vec_t v[10];
    logic [31:0] r;
    int l;
    v[0] = '{32'h3FC00000, 32'h40000000, 3'd0, 32'h40400000, LAT};
    v[1] = '{32'h3FFFFFFF, 32'h3FFFFFFF, 3'd0, 32'h407FFFFE, LAT};
    v[2] = '{32'h3FFFFFFF, 32'h3FFFFFFF, 3'd1, 32'h407FFFFE, LAT};
    v[3] = '{32'h3FFFFFFF, 32'h3FFFFFFF, 3'd3, 32'h407FFFFF, LAT};
    v[4] = '{32'h7F000000, 32'h7F000000, 3'd0, 32'h7F800000, LAT};
    v[5] = '{32'h7F000000, 32'h7F000000, 3'd1, 32'h7F7FFFFF, LAT};
    v[6] = '{32'hFF000000, 32'h7F000000, 3'd3, 32'hFF7FFFFF, LAT};
    v[7] = '{32'h7F800000, 32'h00000000, 3'd0, 32'h7FC00000, 2};
    v[8] = '{32'h80400000, 32'h3F800000, 3'd0, 32'h80000000, 2};
    v[9] = '{32'h12345678, 32'h3F800000, 3'd7, 32'h7FC00000, 2};
    foreach (v[i]) begin
      do_op(v[i].a, v[i].b, v[i].rm, r, l);
      tests++;
      if (r !== v[i].exp) begin
        fails++;
        $display("FAIL dir%0d_rd got %h want %h", i, r, v[i].exp);
      end
      tests++;
      if (l != v[i].lat) begin
        fails++;
        $display("FAIL dir%0d_lat got %0d want %0d", i, l, v[i].lat);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, r, e;
    logic [2:0]  rm;
    bit sp;
    int l, sel;
    for (int n = 0; n < 150; n++) begin
      a = rnd_fp();
      b = rnd_fp();
      sel = $urandom_range(0, 9);
      if (sel == 9)
        rm = 3'($urandom_range(5, 7));
      else
        rm = 3'($urandom_range(0, 4));
      e = ref_mul(a, b, rm, sp);
      do_op(a, b, rm, r, l);
      tests++;
      if (r !== e) begin
        fails++;
        $display("FAIL rnd%0d_rd a=%h b=%h rm=%0d got %h want %h",
                 n, a, b, rm, r, e);
      end
      tests++;
      if (l != (sp ? 2 : LAT)) begin
        fails++;
        $display("FAIL rnd%0d_lat got %0d want %0d",
                 n, l, sp ? 2 : LAT);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    int l, pulses;
    i_rs1    = 32'h3FC00000;
    i_rs2    = 32'h40000000;
    i_funct3 = 3'd0;
    i_valid  = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    #1;
    tests++;
    if (o_ready !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_ready got %b want 0", o_ready);
    end
    tests++;
    if (o_rd !== 32'h0) begin
      fails++;
      $display("FAIL rstmid_rd got %h want 0", o_rd);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    i_rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (o_ready === 1'b1) pulses++;
    end
    tests++;
    if (pulses != 0) begin
      fails++;
      $display("FAIL rstmid_pulse got %0d want 0", pulses);
    end
    do_op(32'h40000000, 32'h40000000, 3'd0, r, l);
    tests++;
    if (r !== 32'h40800000) begin
      fails++;
      $display("FAIL rstmid_after_rd got %h want 40800000", r);
    end
    tests++;
    if (l != LAT) begin
      fails++;
      $display("FAIL rstmid_after_lat got %0d want %0d", l, LAT);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1;
    int l, gap, bad;
    do_op(32'h3FC00000, 32'h40000000, 3'd0, r1, l);
    tests++;
    if (r1 !== 32'h40400000) begin
      fails++;
      $display("FAIL b2b_first got %h want 40400000", r1);
    end
    // do_op left us one cycle past the first o_ready
    i_rs1    = 32'h3FFFFFFF;
    i_rs2    = 32'h3FFFFFFF;
    i_funct3 = 3'd3;
    i_valid  = 1'b1;
    gap = -1;
    bad = 0;
    for (int k = 2; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (o_ready === 1'b1) begin
        gap = k;
        break;
      end
      if (o_rd !== r1) bad++;
    end
    i_valid = 1'b0;
    tests++;
    if (gap != LAT + 1) begin
      fails++;
      $display("FAIL b2b_gap got %0d want %0d", gap, LAT + 1);
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL b2b_hold got %0d bad cycles want 0", bad);
    end
    tests++;
    if (o_rd !== 32'h407FFFFF) begin
      fails++;
      $display("FAIL b2b_second got %h want 407FFFFF", o_rd);
    end
    @(posedge clk);
    #1;
    tests++;
    if (o_ready !== 1'b0) begin
      fails++;
      $display("FAIL b2b_width got %b want 0", o_ready);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
